drc_frm_sched: RTL and testbench
================================

Name: drc_frm_sched

Overview:
Frame scheduler/controller placed in front of the pixel resizer (grayscale/downscale chain) in the DVP-RX path. It aligns the raw DVP pixel stream to frame boundaries and forwards only whole frames. It applies single-shot, continuous and frame-skip capture policies, and regenerates a guaranteed-correct last-pixel flag. Malformed frames are padded or truncated, so the downstream resizer always sees exactly FRM_COL_NUM*FRM_ROW_NUM beats per frame.

Parameters:
I_PXL_W, 16, pixel data width (RGB565)
FRM_COL_NUM, 640, columns per frame
FRM_ROW_NUM, 480, rows per frame
SKIP_W, 4, width of frame-skip configuration
FRM_CNT_W, 16, width of forwarded-frame counter
Derived constants (not overridable): PXL_NUM = FRM_COL_NUM*FRM_ROW_NUM; CNT_W = clog2(PXL_NUM).

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  asynchronous, active-high reset
cfg_cont  in  1  1 = continuous capture, 0 = single frame; sampled on cmd_start
cfg_skip  in  SKIP_W  forward 1 frame out of every cfg_skip+1; sampled on cmd_start
cmd_start  in  1  one-cycle pulse; honoured only in IDLE
cmd_stop  in  1  one-cycle pulse; graceful stop request
i_pxl_dat  in  I_PXL_W  input pixel
i_pxl_sof  in  1  marks the first pixel of a DVP frame (qualified by i_pxl_vld)
i_pxl_vld  in  1  input valid
i_pxl_rdy  out  1  input ready
o_pxl_dat  out  I_PXL_W  pixel to resizer
o_pxl_last  out  1  last pixel of frame
o_pxl_vld  out  1  output valid
o_pxl_rdy  in  1  resizer ready
sts_busy  out  1  state != IDLE
sts_frm_cnt  out  FRM_CNT_W  frames forwarded since start (wraps)
sts_err_short  out  1  sticky: a frame was padded; cleared on cmd_start
sts_err_long  out  1  sticky: a frame was truncated; cleared on cmd_start
irq_frm_done  out  1  one-cycle pulse per forwarded frame

Behaviour:
- Reset: state = IDLE; pix_cnt, skip_cnt, sts_frm_cnt = 0; sticky errors = 0; stop_req = 0; irq = 0. Reset mid-frame aborts the frame with no padding. During reset, i_pxl_rdy = 1 and o_pxl_vld = 0.
- Datapath is zero-latency pass-through. In forward cases: o_pxl_dat = i_pxl_dat, o_pxl_vld = i_pxl_vld, i_pxl_rdy = o_pxl_rdy. In drop cases: i_pxl_rdy = 1 and o_pxl_vld = 0. Beat = vld & rdy.
- States:
  - IDLE: drop all input. On cmd_start: latch cfg; skip_cnt = 0; clear errors and stop_req; go to SYNC. sts_frm_cnt is not cleared.
  - SYNC: drop non-sof beats. A sof beat with skip_cnt == 0 is forwarded in the same cycle (pix_cnt = 1), skip_cnt reloads to cfg_skip, next state is FWD. A sof beat with skip_cnt != 0 is dropped, skip_cnt decrements, state stays SYNC. If stop_req is set on entry, go directly to IDLE.
  - FWD: forward beats and increment pix_cnt. o_pxl_last = (pix_cnt == PXL_NUM-1).
    - On the last beat: sts_frm_cnt++, irq_frm_done pulses the next cycle, pix_cnt = 0, next state is TAIL.
    - If PXL_NUM == 1, the sof beat is also the last beat and the block goes straight to TAIL.
  - TAIL: drop non-sof beats and set sts_err_long on each. A sof beat is handled as in SYNC. Exit to IDLE instead if cfg_cont = 0 or stop_req is set.
    - In TAIL with cfg_cont = 0: the next cycle after entry goes to IDLE; the sof beat is not consumed.
  - PAD: entered from FWD when a vld & sof pixel arrives before the last pixel. That pixel is stalled (i_pxl_rdy = 0). The block drives o_pxl_vld = 1, o_pxl_dat = 0, and o_pxl_last = (pix_cnt == PXL_NUM-1), repeating per o_pxl_rdy handshake until the last pad beat. sts_err_short is set. After the last pad beat: count the frame, pulse irq, then go to TAIL, where the stalled sof is re-evaluated.
- cmd_stop in any state except IDLE sets stop_req. The current frame always completes (including padding) before the block returns to IDLE. cmd_stop in IDLE is ignored.
- cmd_start outside IDLE is ignored. Simultaneous cmd_start and cmd_stop in IDLE: start wins and stop_req is set, so the block syncs, then returns to IDLE without forwarding.
- o_pxl_vld/o_pxl_dat/o_pxl_last hold stable while o_pxl_rdy = 0 (AXI-stream rule). i_pxl_rdy does not depend on o_pxl_rdy in drop states.

Test Plan:
(All with COL=4, ROW=2, PXL_NUM=8, o_pxl_rdy=1 unless stated.)
- Single shot: cfg_cont=0, skip=0, start, then send 3 junk beats, then two 8-beat frames. Expect: junk dropped; 8 beats of frame 1 forwarded with last on beat 8; sts_frm_cnt=1; one irq; frame 2 dropped; block in IDLE.
- Skip: cfg_cont=1, skip=2, 6 frames. Expect frames 1 and 4 forwarded, sts_frm_cnt=2, 2 irqs.
- Short frame: sof arrives after 5 beats. Expect 3 zero pad beats, last on pad 3, sts_err_short=1, next frame forwarded intact.
- Long frame: 11 beats before the next sof. Expect 8 forwarded, 3 dropped, sts_err_long=1, sts_frm_cnt=1.
- Backpressure and stop: o_pxl_rdy toggles randomly; cmd_stop pulsed at beat 3 of a continuous run. Expect data order and values preserved, frame completes with last on beat 8, then IDLE, no further output.
- Async reset asserted mid-frame at beat 4: outputs drop in the same cycle (o_pxl_vld=0, i_pxl_rdy=1), sts_busy=0, counters=0; a subsequent start captures a clean frame.

Source files
------------

// File: rtl/drc_frm_sched.sv
// Frame scheduler ahead of the pixel resizer: aligns the DVP stream to frame starts,
// applies single/continuous/skip capture and pads or truncates frames to PXL_NUM beats.
module drc_frm_sched #(
    parameter int I_PXL_W     = 16,
    parameter int FRM_COL_NUM = 640,
    parameter int FRM_ROW_NUM = 480,
    parameter int SKIP_W      = 4,
    parameter int FRM_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_cont,
    input  logic [SKIP_W-1:0]    cfg_skip,
    input  logic                 cmd_start,
    input  logic                 cmd_stop,
    input  logic [I_PXL_W-1:0]   i_pxl_dat,
    input  logic                 i_pxl_sof,
    input  logic                 i_pxl_vld,
    output logic                 i_pxl_rdy,
    output logic [I_PXL_W-1:0]   o_pxl_dat,
    output logic                 o_pxl_last,
    output logic                 o_pxl_vld,
    input  logic                 o_pxl_rdy,
    output logic                 sts_busy,
    output logic [FRM_CNT_W-1:0] sts_frm_cnt,
    output logic                 sts_err_short,
    output logic                 sts_err_long,
    output logic                 irq_frm_done
);

    localparam int PXL_NUM = FRM_COL_NUM * FRM_ROW_NUM;
    localparam int CNT_W   = (PXL_NUM > 1) ? $clog2(PXL_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PXL_NUM - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_FWD  = 3'd2;
    localparam logic [2:0] S_TAIL = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;

    // Handshake: a beat transfers on a rising edge where vld and rdy are both high.
    // Forwarded beats pass through combinationally; dropped beats see rdy = 1.
    logic [2:0]        state;
    logic [CNT_W-1:0]  pix_cnt;
    logic [SKIP_W-1:0] skip_cnt;
    logic [SKIP_W-1:0] skip_q;
    logic              cont_q;
    logic              stop_req;

    logic at_last;
    logic sync_hit;
    logic tail_exit;
    logic fwd_sel;
    logic fwd_beat;
    logic pad_beat;
    logic frame_done;
    logic drop_sof;

    assign at_last   = (pix_cnt == LAST_IDX);
    assign sync_hit  = i_pxl_sof && (skip_cnt == '0);
    assign tail_exit = !cont_q || stop_req;

    always_comb begin
        o_pxl_dat  = i_pxl_dat;
        o_pxl_vld  = 1'b0;
        o_pxl_last = 1'b0;
        i_pxl_rdy  = 1'b1;
        fwd_sel    = 1'b0;
        case (state)
            S_SYNC: begin
                if (!stop_req && sync_hit) fwd_sel = 1'b1;
            end
            S_FWD: begin
                // an early sof is held back while the frame is padded out
                if (i_pxl_vld && i_pxl_sof) i_pxl_rdy = 1'b0;
                else                        fwd_sel   = 1'b1;
            end
            S_TAIL: begin
                if (tail_exit)     i_pxl_rdy = 1'b0;
                else if (sync_hit) fwd_sel   = 1'b1;
            end
            S_PAD: begin
                o_pxl_vld  = 1'b1;
                o_pxl_dat  = '0;
                o_pxl_last = at_last;
                i_pxl_rdy  = 1'b0;
            end
            default: ;
        endcase
        if (fwd_sel) begin
            o_pxl_vld  = i_pxl_vld;
            o_pxl_last = at_last;
            i_pxl_rdy  = o_pxl_rdy;
        end
    end

    assign fwd_beat   = fwd_sel && i_pxl_vld && o_pxl_rdy;
    assign pad_beat   = (state == S_PAD) && o_pxl_rdy;
    assign frame_done = (fwd_beat || pad_beat) && at_last;
    assign drop_sof   = i_pxl_vld && i_pxl_sof && (skip_cnt != '0);
    assign sts_busy   = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            pix_cnt       <= '0;
            skip_cnt      <= '0;
            skip_q        <= '0;
            cont_q        <= 1'b0;
            stop_req      <= 1'b0;
            sts_frm_cnt   <= '0;
            sts_err_short <= 1'b0;
            sts_err_long  <= 1'b0;
            irq_frm_done  <= 1'b0;
        end else begin
            irq_frm_done <= frame_done;
            if (frame_done) sts_frm_cnt <= sts_frm_cnt + 1'b1;
            if (cmd_stop && state != S_IDLE) stop_req <= 1'b1;

            if (fwd_beat) begin
                if (at_last) begin
                    pix_cnt <= '0;
                    state   <= S_TAIL;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                    state   <= S_FWD;
                end
            end

            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        cont_q        <= cfg_cont;
                        skip_q        <= cfg_skip;
                        skip_cnt      <= '0;
                        sts_err_short <= 1'b0;
                        sts_err_long  <= 1'b0;
                        stop_req      <= cmd_stop;
                        pix_cnt       <= '0;
                        state         <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (stop_req)      state    <= S_IDLE;
                    else if (drop_sof) skip_cnt <= skip_cnt - 1'b1;
                    else if (fwd_beat) skip_cnt <= skip_q;
                end
                S_FWD: begin
                    if (i_pxl_vld && i_pxl_sof) begin
                        sts_err_short <= 1'b1;
                        state         <= S_PAD;
                    end
                end
                S_TAIL: begin
                    if (tail_exit) begin
                        state <= S_IDLE;
                    end else if (i_pxl_vld && !i_pxl_sof) begin
                        sts_err_long <= 1'b1;
                    end else if (drop_sof) begin
                        skip_cnt <= skip_cnt - 1'b1;
                        state    <= S_SYNC;
                    end else if (fwd_beat) begin
                        skip_cnt <= skip_q;
                    end
                end
                S_PAD: begin
                    if (pad_beat) begin
                        if (at_last) begin
                            pix_cnt <= '0;
                            state   <= S_TAIL;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drc_frm_sched.sv
// Bench for drc_frm_sched with a 4x2 frame: scoreboard of expected output beats
// {last, data}, irq counting, output-hold checking and status checks per scenario.
module tb_drc_frm_sched;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_cont = 1'b0;
    logic [3:0]    cfg_skip = '0;
    logic          cmd_start = 1'b0;
    logic          cmd_stop = 1'b0;
    logic [W-1:0]  i_pxl_dat = '0;
    logic          i_pxl_sof = 1'b0;
    logic          i_pxl_vld = 1'b0;
    logic          i_pxl_rdy;
    logic [W-1:0]  o_pxl_dat;
    logic          o_pxl_last;
    logic          o_pxl_vld;
    logic          o_pxl_rdy = 1'b1;
    logic          sts_busy;
    logic [15:0]   sts_frm_cnt;
    logic          sts_err_short;
    logic          sts_err_long;
    logic          irq_frm_done;

    drc_frm_sched #(
        .I_PXL_W(W), .FRM_COL_NUM(4), .FRM_ROW_NUM(2), .SKIP_W(4), .FRM_CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .cfg_cont(cfg_cont), .cfg_skip(cfg_skip),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .i_pxl_dat(i_pxl_dat), .i_pxl_sof(i_pxl_sof), .i_pxl_vld(i_pxl_vld),
        .i_pxl_rdy(i_pxl_rdy), .o_pxl_dat(o_pxl_dat), .o_pxl_last(o_pxl_last),
        .o_pxl_vld(o_pxl_vld), .o_pxl_rdy(o_pxl_rdy), .sts_busy(sts_busy),
        .sts_frm_cnt(sts_frm_cnt), .sts_err_short(sts_err_short),
        .sts_err_long(sts_err_long), .irq_frm_done(irq_frm_done)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int irq_cnt  = 0;
    int exp_frm  = 0;
    logic rnd_bp = 1'b0;
    logic [W:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // backpressure source
    always begin
        @(posedge clk);
        #1;
        o_pxl_rdy = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // scoreboard monitor, irq counter and output-hold checker
    logic       prev_stall = 1'b0;
    logic [W:0] prev_val = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (irq_frm_done) irq_cnt++;
            if (prev_stall) begin
                check("hold_vld", 32'(o_pxl_vld), 32'd1);
                check("hold_dat", 32'({o_pxl_last, o_pxl_dat}), 32'(prev_val));
            end
            if (o_pxl_vld && o_pxl_rdy) begin
                if (exp_q.size() == 0) check("unexpected_beat", 32'({o_pxl_last, o_pxl_dat}), 32'h0dead);
                else check("out_beat", 32'({o_pxl_last, o_pxl_dat}), 32'(exp_q.pop_front()));
            end
            prev_stall = o_pxl_vld && !o_pxl_rdy;
            prev_val   = {o_pxl_last, o_pxl_dat};
        end
    end

    // driver tasks
    task automatic send_beat(input logic [W-1:0] d, input logic s);
        int  n;
        logic acc;
        i_pxl_vld = 1'b1;
        i_pxl_dat = d;
        i_pxl_sof = s;
        n = 0;
        do begin
            @(negedge clk);
            acc = i_pxl_rdy;
            @(posedge clk);
            #1;
            cmd_stop = 1'b0;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        i_pxl_vld = 1'b0;
        i_pxl_sof = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input logic c, input logic [3:0] s, input logic stp);
        cfg_cont  = c;
        cfg_skip  = s;
        cmd_start = 1'b1;
        cmd_stop  = stp;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1;
        @(posedge clk);
        #1;
        cmd_stop = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] base, input int n, input int stop_at);
        for (int i = 0; i < n; i++) begin
            if (i == stop_at) cmd_stop = 1'b1;
            send_beat(W'(base + W'(i)), i == 0);
        end
    endtask

    // expected output of one frame: nreal data beats then zero padding to 8
    task automatic push_frm(input logic [W-1:0] base, input int nreal);
        for (int i = 0; i < 8; i++)
            exp_q.push_back({i == 7, (i < nreal) ? W'(base + W'(i)) : W'(0)});
    endtask

    task automatic end_checks(input string tag, input int irqs);
        idle(4);
        check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_frm_cnt"}, 32'(sts_frm_cnt), 32'(exp_frm));
        check({tag, "_irq"}, 32'(irq_cnt), 32'(irqs));
        check({tag, "_busy"}, 32'(sts_busy), 32'd0);
        irq_cnt = 0;
    endtask

    initial begin
        #1;
        check("rst_i_rdy", 32'(i_pxl_rdy), 32'd1);
        check("rst_o_vld", 32'(o_pxl_vld), 32'd0);
        check("rst_busy", 32'(sts_busy), 32'd0);
        check("rst_frm_cnt", 32'(sts_frm_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // single shot: junk dropped, frame 1 forwarded, frame 2 dropped
        start(1'b0, 4'd0, 1'b0);
        check("sync_busy", 32'(sts_busy), 32'd1);
        for (int i = 0; i < 3; i++) send_beat(W'(16'h0e0 + i), 1'b0);
        push_frm(16'h0100, 8);
        send_frame(16'h0100, 8, -1);
        send_frame(16'h0200, 8, -1);
        exp_frm += 1;
        end_checks("single", 1);

        // skip = 2: frames 1 and 4 of 6 forwarded
        start(1'b1, 4'd2, 1'b0);
        for (int f = 0; f < 6; f++) begin
            if (f == 0 || f == 3) push_frm(W'(16'h1000 + f * 16'h100), 8);
            send_frame(W'(16'h1000 + f * 16'h100), 8, -1);
        end
        idle(2);
        pulse_stop();
        exp_frm += 2;
        end_checks("skip", 2);

        // short frame padded, following frame intact
        start(1'b1, 4'd0, 1'b0);
        push_frm(16'h2000, 5);
        push_frm(16'h2100, 8);
        send_frame(16'h2000, 5, -1);
        send_frame(16'h2100, 8, -1);
        idle(2);
        pulse_stop();
        exp_frm += 2;
        end_checks("short", 2);
        check("short_err_short", 32'(sts_err_short), 32'd1);
        check("short_err_long", 32'(sts_err_long), 32'd0);

        // long frame truncated
        start(1'b1, 4'd0, 1'b0);
        push_frm(16'h3000, 8);
        send_frame(16'h3000, 11, -1);
        idle(2);
        pulse_stop();
        exp_frm += 1;
        end_checks("long", 1);
        check("long_err_long", 32'(sts_err_long), 32'd1);
        check("long_err_short", 32'(sts_err_short), 32'd0);

        // random backpressure, stop at beat 3 of a continuous run
        rnd_bp = 1'b1;
        start(1'b1, 4'd0, 1'b0);
        push_frm(16'h4000, 8);
        send_frame(16'h4000, 8, 2);
        send_frame(16'h4100, 8, -1);
        exp_frm += 1;
        end_checks("stop", 1);
        rnd_bp = 1'b0;
        idle(2);

        // async reset mid-frame at beat 4, then a clean capture
        start(1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, W'(16'h5000 + i)});
        send_frame(16'h5000, 3, -1);
        i_pxl_vld = 1'b1;
        i_pxl_sof = 1'b0;
        i_pxl_dat = 16'h5003;
        #2;
        rst = 1'b1;
        #1;
        check("arst_o_vld", 32'(o_pxl_vld), 32'd0);
        check("arst_i_rdy", 32'(i_pxl_rdy), 32'd1);
        check("arst_busy", 32'(sts_busy), 32'd0);
        check("arst_frm_cnt", 32'(sts_frm_cnt), 32'd0);
        i_pxl_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_frm = 0;
        irq_cnt = 0;
        check("arst_q_empty", 32'(exp_q.size()), 32'd0);
        start(1'b0, 4'd0, 1'b0);
        push_frm(16'h6000, 8);
        send_frame(16'h6000, 8, -1);
        exp_frm += 1;
        end_checks("after_rst", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
